cpu_ifetch_ctrl: RTL and testbench

Instruction fetch controller for the moxie core. It issues 32-bit word reads to instruction memory and buffers the results as a halfword queue. It presents the decode stage with a 16-bit instruction and a 32-bit immediate, each with its own valid flag. It retires queue entries on the decoder's used_insn/used_data pulses and redirects fetch on a flush from branch/jump resolution.

---
 rtl/cpu_ifetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cpu_ifetch_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ifetch_ctrl.sv
// cpu_ifetch_ctrl: instruction fetch controller for the moxie core.
// Issues 32-bit word reads, buffers the returned data as a halfword queue and
// presents decode with the head instruction plus the following 32-bit immediate.
// Optional trace output: define CPU_IFETCH_TRACE_EN to print pops and flushes.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | no request; queue too full to accept another word
// S_REQ     | request at fetch_addr held until ack; ack data is queued
// S_DISCARD | request issued before a flush still outstanding; its data is dropped
module cpu_ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int          QDEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [15:0] ifid_insn_o,
  output logic [31:0] ifid_insn_data_o,
  output logic        ifid_insn_valid_o,
  output logic        ifid_insn_data_valid_o,
  output logic [31:0] ifid_pc_o,
  input  logic        idif_used_insn_i,
  input  logic        idif_used_data_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t          state_q, state_d;
  logic [15:0]     queue_q [QDEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     fetch_addr_q;
  logic [31:0]     discard_addr_q;
  logic [31:0]     pc_q;
  logic            skip_hi_q;

  logic [CW-1:0]   pop_req, pop_amt, push_amt, count_nxt;
  logic            push_en;
  logic            room;

  // Pop/push amounts for this cycle; flush overrides both, oversized pops are ignored.
  always_comb begin
    pop_req = '0;
    if (idif_used_insn_i) pop_req = idif_used_data_i ? CW'(3) : CW'(1);
    pop_amt   = (!flush_i && (pop_req <= count_q)) ? pop_req : '0;
    push_en   = (state_q == S_REQ) && imem_ack_i && !flush_i;
    push_amt  = push_en ? (skip_hi_q ? CW'(1) : CW'(2)) : '0;
    count_nxt = count_q + push_amt - pop_amt;
    // A new word may be requested only if a full word still fits afterwards,
    // which is why the queue can never overflow.
    room      = (count_nxt <= CW'(QDEPTH - 2));
  end

  // Next-state and memory request outputs.
  always_comb begin
    state_d     = state_q;
    imem_req_o  = 1'b0;
    imem_addr_o = fetch_addr_q;
    case (state_q)
      S_IDLE: begin
        if (flush_i || room) state_d = S_REQ;
      end
      S_REQ: begin
        imem_req_o = 1'b1;
        if (flush_i)                 state_d = imem_ack_i ? S_REQ : S_DISCARD;
        else if (imem_ack_i && !room) state_d = S_IDLE;
      end
      S_DISCARD: begin
        imem_req_o  = 1'b1;
        imem_addr_o = discard_addr_q;
        if (imem_ack_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Queue pointers, count, fetch address and decode PC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      fetch_addr_q   <= RESET_PC & ~32'd3;
      discard_addr_q <= '0;
      pc_q           <= RESET_PC;
      skip_hi_q      <= RESET_PC[1];
    end else if (flush_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      fetch_addr_q <= flush_pc_i & ~32'd3;
      pc_q         <= flush_pc_i;
      skip_hi_q    <= flush_pc_i[1];
      // Remember the address of the orphaned request so it stays stable until acked.
      if (state_q == S_REQ && !imem_ack_i) discard_addr_q <= fetch_addr_q;
    end else begin
      count_q <= count_nxt;
      head_q  <= head_q + PW'(pop_amt);
      pc_q    <= pc_q + 32'({pop_amt, 1'b0});
      if (push_en) begin
        tail_q       <= tail_q + PW'(push_amt);
        fetch_addr_q <= fetch_addr_q + 32'd4;
        skip_hi_q    <= 1'b0;
      end
    end
  end

  // Halfword storage; big-endian, so the upper halfword goes in first.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      if (skip_hi_q) begin
        queue_q[tail_q] <= imem_data_i[15:0];
      end else begin
        queue_q[tail_q]          <= imem_data_i[31:16];
        queue_q[tail_q + PW'(1)] <= imem_data_i[15:0];
      end
    end
  end

  // Decode-side outputs, zeroed while their valid flag is low.
  always_comb begin
    ifid_insn_valid_o      = (count_q != '0);
    ifid_insn_data_valid_o = (count_q >= CW'(3));
    ifid_insn_o            = ifid_insn_valid_o ? queue_q[head_q] : 16'h0000;
    ifid_insn_data_o       = ifid_insn_data_valid_o ?
                             {queue_q[head_q + PW'(1)], queue_q[head_q + PW'(2)]} : 32'h0;
    ifid_pc_o              = pc_q;
  end

`ifdef CPU_IFETCH_TRACE_EN
  // Trace of each pop and flush as seen by decode.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (flush_i) begin
        $display("flush -> %h", flush_pc_i);
      end else if (pop_amt == CW'(3)) begin
        $display("pop pc=%h insn=%h imm=%h", pc_q, ifid_insn_o, ifid_insn_data_o);
      end else if (pop_amt == CW'(1)) begin
        $display("pop pc=%h insn=%h", pc_q, ifid_insn_o);
      end
    end
  end
`else
  // Default build: no simulation output.
`endif

endmodule

// File: tb/tb_cpu_ifetch_ctrl.sv
// Bench for cpu_ifetch_ctrl: randomized and directed stimulus against a
// halfword-stream reference model, checked through an expectation queue.
module tb_cpu_ifetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam int          QD  = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        idif_used_insn_i = 1'b0;
  logic        idif_used_data_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [15:0] ifid_insn_o;
  logic [31:0] ifid_insn_data_o;
  logic        ifid_insn_valid_o;
  logic        ifid_insn_data_valid_o;
  logic [31:0] ifid_pc_o;

  always #5 clk = ~clk;

  cpu_ifetch_ctrl #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .imem_req_o            (imem_req_o),
    .imem_addr_o           (imem_addr_o),
    .imem_ack_i            (imem_ack_i),
    .imem_data_i           (imem_data_i),
    .ifid_insn_o           (ifid_insn_o),
    .ifid_insn_data_o      (ifid_insn_data_o),
    .ifid_insn_valid_o     (ifid_insn_valid_o),
    .ifid_insn_data_valid_o(ifid_insn_data_valid_o),
    .ifid_pc_o             (ifid_pc_o),
    .idif_used_insn_i      (idif_used_insn_i),
    .idif_used_data_i      (idif_used_data_i),
    .flush_i               (flush_i),
    .flush_pc_i            (flush_pc_i)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic        dv;
    logic [15:0] insn;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  // Reference model: the decode stream is simply memory content read in order.
  logic [15:0] mq[$];
  logic [31:0] m_pc = RPC;
  logic [31:0] m_fetch = RPC & ~32'd3;
  logic [31:0] m_stale = '0;
  bit          m_skip = 1'b0;
  bit          m_discard = 1'b0;
  bit          m_req = 1'b0;

  logic [31:0] mem_ovr [bit [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0] ^ 16'h5A3C, a[15:0] + 16'h0101};
  endfunction

  // One clock of stimulus; the model's view after the coming edge is queued.
  task automatic step(input bit ack, input bit ui, input bit ud, input bit fl,
                      input bit rst, input logic [31:0] fpc);
    exp_t        e;
    int          n;
    logic [31:0] w;
    bit          ack_eff;
    @(negedge clk);
    ack_eff          = ack && m_req;
    rst_i            = rst;
    flush_i          = fl;
    flush_pc_i       = fpc;
    idif_used_insn_i = ui;
    idif_used_data_i = ud;
    imem_ack_i       = ack_eff;
    imem_data_i      = mem_word(imem_addr_o);
    if (rst) begin
      mq.delete();
      m_pc      = RPC;
      m_fetch   = RPC & ~32'd3;
      m_skip    = RPC[1];
      m_discard = 1'b0;
      m_req     = 1'b0;
    end else if (fl) begin
      if (m_req && !ack_eff) begin
        if (!m_discard) m_stale = m_fetch;
        m_discard = 1'b1;
      end else begin
        m_discard = 1'b0;
      end
      mq.delete();
      m_pc    = fpc;
      m_fetch = fpc & ~32'd3;
      m_skip  = fpc[1];
      m_req   = 1'b1;
    end else begin
      n = ui ? (ud ? 3 : 1) : 0;
      if (n > mq.size()) n = 0;
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      m_pc = m_pc + 32'(2 * n);
      if (ack_eff) begin
        if (m_discard) begin
          m_discard = 1'b0;
        end else begin
          w = mem_word(m_fetch);
          if (!m_skip) mq.push_back(w[31:16]);
          mq.push_back(w[15:0]);
          m_skip  = 1'b0;
          m_fetch = m_fetch + 32'd4;
        end
      end
      m_req = (mq.size() <= QD - 2);
    end
    e.req  = m_req;
    e.addr = m_discard ? m_stale : m_fetch;
    e.iv   = (mq.size() >= 1);
    e.dv   = (mq.size() >= 3);
    e.insn = e.iv ? mq[0] : 16'h0;
    e.data = e.dv ? {mq[1], mq[2]} : 32'h0;
    e.pc   = m_pc;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against each queued expectation after every edge.
  exp_t mon_e;
  bit   mon_ok;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e  = exp_q.pop_front();
        checks++;
        mon_ok = (imem_req_o === mon_e.req) &&
                 (!mon_e.req || (imem_addr_o === mon_e.addr)) &&
                 (ifid_insn_valid_o === mon_e.iv) &&
                 (ifid_insn_data_valid_o === mon_e.dv) &&
                 (ifid_insn_o === mon_e.insn) &&
                 (ifid_insn_data_o === mon_e.data) &&
                 (ifid_pc_o === mon_e.pc);
        if (mon_ok) passed++;
        else $display("FAIL scoreboard cyc=%0d got req=%b addr=%h iv=%b dv=%b insn=%h data=%h pc=%h want req=%b addr=%h iv=%b dv=%b insn=%h data=%h pc=%h",
                      cyc, imem_req_o, imem_addr_o, ifid_insn_valid_o, ifid_insn_data_valid_o,
                      ifid_insn_o, ifid_insn_data_o, ifid_pc_o,
                      mon_e.req, mon_e.addr, mon_e.iv, mon_e.dv, mon_e.insn, mon_e.data, mon_e.pc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    mem_ovr[32'h0000_1000] = 32'h0120_0000;
    mem_ovr[32'h0000_1004] = 32'hDEAD_BEEF;
    mem_ovr[32'h0000_3000] = 32'h5555_0120;
    mem_ovr[32'h0000_3004] = 32'hDEAD_BEEF;

    // Reset, then zero-wait memory with no pops until the queue is full.
    repeat (2) step(0, 0, 0, 0, 1, 32'h0);
    repeat (8) step(1, 0, 0, 0, 0, 32'h0);
    // Full queue: one pop leaves 7 (still idle), a second pop resumes fetch.
    step(1, 1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 0, 32'h0);
    repeat (2) step(0, 0, 0, 0, 0, 32'h0);

    // Flush to an odd halfword with a coincident ack, then 0120 + DEADBEEF, pop 3.
    step(1, 0, 0, 1, 0, 32'h0000_3002);
    repeat (2) step(1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 0, 32'h0);

    // Flush while a request is pending; the stale ack comes three cycles later.
    step(0, 0, 0, 1, 0, 32'h0000_2002);
    repeat (2) step(0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);

    // Flush together with ack and used_insn.
    step(1, 1, 0, 1, 0, 32'h0000_4000);
    step(0, 0, 0, 0, 0, 32'h0);

    // Reset while a request is pending and acked in the reset cycle.
    step(0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 1, 32'h0);
    repeat (6) step(1, 0, 0, 0, 0, 32'h0);

    // Randomized traffic with alternating light and heavy decode demand.
    for (int i = 0; i < 3000; i++) begin
      bit          ui, ud;
      int          r, pop_pct;
      logic [31:0] fpc;
      pop_pct = ((i / 150) % 2 == 1) ? 70 : 10;
      ui = 1'b0;
      ud = 1'b0;
      if ($urandom_range(0, 99) < pop_pct) begin
        r = $urandom_range(0, 2);
        if (r == 0) ui = 1'b1;
        else if (r == 1) begin ui = 1'b1; ud = 1'b1; end
        else ud = 1'b1;
      end
      if (ui && ud && mq.size() < 3) ud = 1'b0;
      if (ui && mq.size() < 1) ui = 1'b0;
      fpc = $urandom_range(0, 32'hFFFF) << 1;
      step($urandom_range(0, 9) < 6, ui, ud, $urandom_range(0, 59) == 0,
           $urandom_range(0, 299) == 0, fpc);
    end

    @(posedge clk);
    #3;
    if (passed != checks)
      $display("FAIL summary: got %0d passing cycles, want %0d", passed, checks);
    if (checks < 3000)
      $display("FAIL coverage: got %0d checked cycles, want at least 3000", checks);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
